// File: rtl/jtag_bus_pkg.sv
// Shared definitions for the JTAG bus master: FSM encoding, command-word
// field layout and the value of the bus outputs when the master is idle.
package jtag_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RES,
      ST_REQ,
      ST_BEGIN,
      ST_WDATA,
      ST_RDATA,
      ST_END,
      ST_ABORT
   } state_e;

   // cmd_word = {read_n_write, byte_enable[3:0], burst_size[7:0], address[31:0]}
   localparam int CMD_W     = 45;
   localparam int ADDR_LSB  = 0;
   localparam int ADDR_W    = 32;
   localparam int BURST_LSB = 32;
   localparam int BURST_W   = 8;
   localparam int BE_LSB    = 40;
   localparam int BE_W      = 4;
   localparam int RNW_BIT   = 44;

   // Everything the master drives onto the bus, kept together so the whole
   // set can be returned to idle in one assignment.
   typedef struct packed {
      logic [ADDR_W-1:0]  addr_data;
      logic [BE_W-1:0]    byte_en;
      logic [BURST_W-1:0] burst;
      logic               rnw;
      logic               begin_t;
      logic               end_t;
      logic               dvalid;
   } bus_out_t;

   localparam bus_out_t BUS_IDLE = '0;

endpackage

// File: rtl/jtag_bus_fifo.sv
// Synchronous show-ahead FIFO with occupancy output. A push and a pop in the
// same cycle leave the level unchanged, including when the FIFO is full.
module jtag_bus_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage write port.
   // NOTE: the storage array has no reset; the level counter alone decides
   // which entries are meaningful, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/jtag_bus_master.sv
// Command-driven burst master: buffers write data and read data in FIFOs,
// reserves FIFO resources for a whole burst before requesting the bus, then
// runs begin / data / end phases with abort on slave error or timeout.
module jtag_bus_master
   import jtag_bus_pkg::*;
#(
   parameter int BURST_MAX      = 16,
   parameter int FIFO_DEPTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              system_clock,
   input  logic              system_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CMD_W-1:0]  cmd_word,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [31:0]       wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [31:0]       rdata,
   output logic [1:0]        status,
   output logic [31:0]       address_dataOUT,
   output logic [3:0]        byte_enableOUT,
   output logic [7:0]        burst_sizeOUT,
   output logic              read_n_writeOUT,
   output logic              begin_transactionOUT,
   output logic              end_transactionOUT,
   output logic              data_validOUT,
   output logic              busyOUT,
   input  logic [31:0]       address_dataIN,
   input  logic              end_transactionIN,
   input  logic              data_validIN,
   input  logic              busyIN,
   input  logic              errorIN,
   output logic              request,
   input  logic              granted
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
   localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [BE_W-1:0]    be_q;
   logic [BURST_W-1:0] burst_q;
   logic               rnw_q;
   logic [8:0]         beat_cnt_q;   // words popped (write) or stored (read)
   logic [TW-1:0]      timer_q;
   logic [1:0]         status_q;     // {timeout, error}
   logic               request_q;
   bus_out_t           bus_q;

   logic [BURST_W-1:0] cmd_burst;
   logic [BURST_W-1:0] cmd_burst_clamped;
   logic [8:0]         burst_words;
   logic               last_beat;
   logic               res_ok;
   logic [LW-1:0]      wlevel;
   logic [LW-1:0]      rlevel;
   logic [31:0]        wfifo_head;
   logic [31:0]        rfifo_head;
   logic               wfifo_push;
   logic               wfifo_pop;
   logic               rfifo_push;
   logic               rfifo_pop;
   logic               rfifo_empty;

   assign cmd_burst         = cmd_word[BURST_LSB +: BURST_W];
   assign cmd_burst_clamped = (cmd_burst > BURST_LAST) ? BURST_LAST : cmd_burst;
   assign burst_words       = {1'b0, burst_q} + 9'd1;
   assign last_beat         = (beat_cnt_q == burst_words);

   // Resources for the whole burst must be in place before the bus is requested,
   // so a read burst can never stall the slave.
   assign res_ok = rnw_q ? ((32'(FIFO_DEPTH) - 32'(rlevel)) >= 32'(burst_words))
                         : (32'(wlevel) >= 32'(burst_words));

   assign wdata_ready = (wlevel != LW'(FIFO_DEPTH));
   assign wfifo_push  = wdata_valid & wdata_ready;
   assign rfifo_empty = (rlevel == '0);
   assign rdata_valid = ~rfifo_empty;
   assign rdata       = rfifo_empty ? '0 : rfifo_head;
   assign rfifo_pop   = rdata_valid & rdata_ready;

   assign cmd_ready            = (state_q == ST_IDLE);
   assign status               = status_q;
   assign request              = request_q;
   assign busyOUT              = 1'b0;
   assign address_dataOUT      = bus_q.addr_data;
   assign byte_enableOUT       = bus_q.byte_en;
   assign burst_sizeOUT        = bus_q.burst;
   assign read_n_writeOUT      = bus_q.rnw;
   assign begin_transactionOUT = bus_q.begin_t;
   assign end_transactionOUT   = bus_q.end_t;
   assign data_validOUT        = bus_q.dvalid;

   // FIFO strobes that must act on the same edge the FSM decides on.
   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      wfifo_pop  = 1'b0;
      rfifo_push = 1'b0;
      case (state_q)
         ST_BEGIN: wfifo_pop  = ~rnw_q & ~errorIN;
         ST_WDATA: wfifo_pop  = ~errorIN & ~busyIN & ~last_beat;
         ST_ABORT: wfifo_pop  = ~rnw_q & ~last_beat;
         ST_RDATA: rfifo_push = ~errorIN & data_validIN & ~last_beat;
         default:  ;
      endcase
   end

   // Transaction FSM with registered bus, request and status outputs.
   always_ff @(posedge system_clock or negedge system_reset) begin
      if (!system_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         be_q       <= '0;
         burst_q    <= '0;
         rnw_q      <= 1'b0;
         beat_cnt_q <= '0;
         timer_q    <= '0;
         status_q   <= '0;
         request_q  <= 1'b0;
         bus_q      <= BUS_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bus_q <= BUS_IDLE;
               if (cmd_valid) begin
                  addr_q     <= cmd_word[ADDR_LSB +: ADDR_W];
                  be_q       <= cmd_word[BE_LSB +: BE_W];
                  rnw_q      <= cmd_word[RNW_BIT];
                  burst_q    <= cmd_burst_clamped;
                  beat_cnt_q <= '0;
                  status_q   <= '0;
                  state_q    <= ST_WAIT_RES;
               end
            end
            ST_WAIT_RES: begin
               if (res_ok) begin
                  request_q <= 1'b1;
                  state_q   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (granted) begin
                  request_q     <= 1'b0;
                  bus_q         <= BUS_IDLE;
                  bus_q.addr_data <= addr_q;
                  bus_q.byte_en <= be_q;
                  bus_q.burst   <= burst_q;
                  bus_q.rnw     <= rnw_q;
                  bus_q.begin_t <= 1'b1;
                  state_q       <= ST_BEGIN;
               end
            end
            ST_BEGIN: begin
               timer_q <= '0;
               bus_q   <= BUS_IDLE;
               if (errorIN) begin
                  status_q[0] <= 1'b1;
                  bus_q.end_t <= 1'b1;
                  state_q     <= ST_ABORT;
               end else if (rnw_q) begin
                  state_q <= ST_RDATA;
               end else begin
                  bus_q.addr_data <= wfifo_head;
                  bus_q.dvalid    <= 1'b1;
                  beat_cnt_q      <= 9'd1;
                  state_q         <= ST_WDATA;
               end
            end
            ST_WDATA: begin
               if (errorIN) begin
                  status_q[0] <= 1'b1;
                  bus_q       <= BUS_IDLE;
                  bus_q.end_t <= 1'b1;
                  state_q     <= ST_ABORT;
               end else if (busyIN) begin
                  if (timer_q == TIMER_LAST) begin
                     status_q[1] <= 1'b1;
                     bus_q       <= BUS_IDLE;
                     bus_q.end_t <= 1'b1;
                     state_q     <= ST_ABORT;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end else begin
                  timer_q <= '0;
                  if (last_beat) begin
                     bus_q       <= BUS_IDLE;
                     bus_q.end_t <= 1'b1;
                     state_q     <= ST_END;
                  end else begin
                     bus_q.addr_data <= wfifo_head;
                     beat_cnt_q      <= beat_cnt_q + 9'd1;
                  end
               end
            end
            ST_RDATA: begin
               if (errorIN) begin
                  status_q[0] <= 1'b1;
                  bus_q.end_t <= 1'b1;
                  state_q     <= ST_ABORT;
               end else begin
                  if (data_validIN) begin
                     timer_q <= '0;
                     if (last_beat) status_q[0] <= 1'b1;   // surplus word dropped
                     else           beat_cnt_q  <= beat_cnt_q + 9'd1;
                  end else if (timer_q != TIMER_LAST) begin
                     timer_q <= timer_q + TW'(1);
                  end
                  if (end_transactionIN) begin
                     state_q <= ST_IDLE;
                  end else if (!data_validIN && timer_q == TIMER_LAST) begin
                     status_q[1] <= 1'b1;
                     bus_q.end_t <= 1'b1;
                     state_q     <= ST_ABORT;
                  end
               end
            end
            ST_END: begin
               bus_q   <= BUS_IDLE;
               state_q <= ST_IDLE;
            end
            ST_ABORT: begin
               // Drop the unsent remainder of a write burst, one word per cycle.
               bus_q <= BUS_IDLE;
               if (rnw_q || last_beat) state_q    <= ST_IDLE;
               else                    beat_cnt_q <= beat_cnt_q + 9'd1;
            end
            default: begin
               bus_q   <= BUS_IDLE;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   jtag_bus_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wfifo (
      .clk     (system_clock),
      .rst_n   (system_reset),
      .push_i  (wfifo_push),
      .pop_i   (wfifo_pop),
      .wdata_i (wdata),
      .rdata_o (wfifo_head),
      .level_o (wlevel)
   );

   jtag_bus_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rfifo (
      .clk     (system_clock),
      .rst_n   (system_reset),
      .push_i  (rfifo_push),
      .pop_i   (rfifo_pop),
      .wdata_i (address_dataIN),
      .rdata_o (rfifo_head),
      .level_o (rlevel)
   );

endmodule
